// File: rtl/mpu6050_sampler.sv
// Periodic MPU6050 accelerometer sampler: sequences six single-register reads
// through i2c_master and publishes signed X/Y/Z words with a one-cycle strobe.
module mpu6050_sampler #(
  parameter logic [7:0]  BASE_REG       = 8'h3B,
  parameter int unsigned SAMPLE_PERIOD  = 500000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [7:0]  i2c_data_in,
  output logic        i2c_start,
  input  logic [7:0]  i2c_data_out,
  input  logic        i2c_data_out_available,
  input  logic        i2c_master_available,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int unsigned CNT_MAX = (SAMPLE_PERIOD > TIMEOUT_CYCLES) ? SAMPLE_PERIOD : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] WD_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    ISSUE,
    WAIT_ACCEPT,
    WAIT_DATA,
    WAIT_RELEASE,
    PUBLISH
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [2:0]      idx_nxt;
  logic [5:0][7:0] slot;
  logic            avail_q;
  logic            data_rise;
  logic            wd_expired;
  logic            capture;
  logic            abort;

  assign data_rise  = i2c_data_out_available & ~avail_q;
  assign wd_expired = (cnt == WD_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          idx_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          idx_nxt   = '0;
          state_nxt = enable ? ISSUE : IDLE;
        end
      end
      ISSUE: state_nxt = WAIT_ACCEPT;
      WAIT_ACCEPT: begin
        if (wd_expired) begin
          abort = 1'b1;
        end else if (!i2c_master_available) begin
          state_nxt = WAIT_DATA;
        end
      end
      // Watchdog is tested first so a data edge in the expiry cycle is ignored.
      WAIT_DATA: begin
        if (wd_expired) begin
          abort = 1'b1;
        end else if (data_rise) begin
          capture   = 1'b1;
          state_nxt = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (wd_expired) begin
          abort = 1'b1;
        end else if (i2c_master_available) begin
          if (idx == 3'd5) begin
            state_nxt = PUBLISH;
          end else begin
            idx_nxt   = idx + 3'd1;
            state_nxt = ISSUE;
          end
        end
      end
      PUBLISH: state_nxt = GAP;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = GAP;
    end
  end

  // Outputs are registered from the next state so start/busy line up with the
  // state they describe while remaining glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      idx          <= '0;
      avail_q      <= 1'b0;
      slot         <= '0;
      i2c_start    <= 1'b0;
      i2c_data_in  <= BASE_REG;
      accel_x      <= '0;
      accel_y      <= '0;
      accel_z      <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      avail_q      <= i2c_data_out_available;
      idx          <= idx_nxt;
      i2c_start    <= (state_nxt == WAIT_ACCEPT);
      busy         <= !(state_nxt inside {IDLE, GAP});
      sample_valid <= (state == PUBLISH);

      if (state_nxt != state || state == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (state == ISSUE) begin
        i2c_data_in <= BASE_REG + {5'b0, idx};
      end

      if (capture) begin
        slot[idx] <= i2c_data_out;
      end

      if (abort) begin
        timeout_err <= 1'b1;
        slot        <= '0;
      end

      if (state == PUBLISH) begin
        accel_x     <= {slot[0], slot[1]};
        accel_y     <= {slot[2], slot[3]};
        accel_z     <= {slot[4], slot[5]};
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mpu6050_sampler.md
# mpu6050_sampler

Sequencer that sits in front of `i2c_master` in the MPU6050 sensor path and turns it into a periodic 3-axis accelerometer sampler. It issues six single-register reads (0x3B..0x40 by default) back-to-back, assembles the bytes into signed 16-bit X/Y/Z words, and publishes them atomically with a one-cycle valid strobe. A watchdog aborts any frame whose I2C transaction stalls.

## Interface
- `BASE_REG`, 8'h3B, address of the first register read; the frame reads `BASE_REG`..`BASE_REG+5`.
- `SAMPLE_PERIOD`, 500000, idle cycles between the end of one frame and the start of the next; must be ≥1.
- `TIMEOUT_CYCLES`, 100000, maximum cycles spent in any single wait state before the frame aborts; must be ≥2.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; when high, frames run periodically.
- `i2c_data_in`  out  8  register address presented to `i2c_master.data_in`.
- `i2c_start`  out  1  to `i2c_master.start`.
- `i2c_data_out`  in  8  from `i2c_master.data_out`.
- `i2c_data_out_available`  in  1  from `i2c_master.data_out_available`.
- `i2c_master_available`  in  1  from `i2c_master.i2c_master_available`.
- `accel_x`, `accel_y`, `accel_z`  out  16 each  last published sample, two's complement.
- `sample_valid`  out  1  one-cycle pulse when the `accel_*` outputs update.
- `busy`  out  1  high from frame start until publish or abort.
- `timeout_err`  out  1  sticky error flag.

## Operation
- States: IDLE, GAP, ISSUE, WAIT_ACCEPT, WAIT_DATA, WAIT_RELEASE, PUBLISH.
- IDLE: `enable`=1 → ISSUE with byte index 0. The first frame starts without a gap.
- ISSUE: drive `i2c_data_in`=`BASE_REG`+index and `i2c_start`=1, then go to WAIT_ACCEPT.
- WAIT_ACCEPT: hold `i2c_start`=1 and `i2c_data_in` stable until `i2c_master_available`=0, then drop `i2c_start` and go to WAIT_DATA.
- WAIT_DATA: on the rising edge of `i2c_data_out_available`, capture `i2c_data_out` into byte slot[index], then go to WAIT_RELEASE.
- WAIT_RELEASE: wait for `i2c_master_available`=1.
  - If index<5: increment index → ISSUE.
  - If index=5: → PUBLISH.
- Byte slots map big-endian:
  - `accel_x` = {slot0, slot1}
  - `accel_y` = {slot2, slot3}
  - `accel_z` = {slot4, slot5}
- PUBLISH: copy all three words to the outputs in one cycle, pulse `sample_valid`, clear `timeout_err`, then go to GAP.
- GAP: count `SAMPLE_PERIOD` cycles.
  - If `enable`=0 at expiry: → IDLE.
  - Otherwise: → ISSUE with index 0.
- Watchdog:
  - The counter resets on every entry to WAIT_ACCEPT, WAIT_DATA and WAIT_RELEASE.
  - When it reaches `TIMEOUT_CYCLES` in any of these states: set `timeout_err`, drop `i2c_start`, discard partial slots (outputs unchanged, no `sample_valid`), then go to GAP.
- `enable` falling mid-frame does not abort; the current frame completes or times out.
- `enable` is sampled only in IDLE and at GAP expiry.
- `busy` = 1 in ISSUE, WAIT_ACCEPT, WAIT_DATA, WAIT_RELEASE and PUBLISH.

## Timing
- Reset (async, `reset`=0) forces:
  - state IDLE;
  - `i2c_start`=0, `i2c_data_in`=`BASE_REG`;
  - `accel_x`/`accel_y`/`accel_z`=0;
  - `sample_valid`=0, `busy`=0, `timeout_err`=0;
  - counters 0, slots 0.
- Reset mid-transaction also drops `i2c_start` immediately. The master must be reset by the same signal.
- All outputs are registered.
- `i2c_start` rises the cycle after ISSUE is entered and is held at least until the master deasserts `i2c_master_available`.
- `i2c_data_in` changes only in ISSUE.
- Data capture is edge-detected using one registered copy of `i2c_data_out_available`. A level held across the WAIT_RELEASE→ISSUE boundary is not recaptured.
- `sample_valid` is high for exactly 1 cycle, in the same cycle the new `accel_*` values first appear.
- Frame latency = sum of 6 master transactions + ≤4 control cycles per byte + 1 publish cycle.
- GAP is exactly `SAMPLE_PERIOD` cycles, measured from the cycle after PUBLISH or abort.
- If `i2c_data_out_available` rises in the same cycle the timeout fires, the timeout takes precedence.

## Test plan
- **Basic frame:** use a slave model on `SDA_BUS` behind a real `i2c_master` (DIV_FACTOR=16) returning 0x12,0x34,0xFE,0xDC,0x00,0x80 for 0x3B..0x40; `SAMPLE_PERIOD`=100; `enable`=1 → `i2c_data_in` sequence 0x3B..0x40, then one `sample_valid` with `accel_x`=0x1234, `accel_y`=0xFEDC (−292), `accel_z`=0x0080.
- **Periodicity:** keep `enable`=1 for 3 frames → exactly 3 `sample_valid` pulses, each spaced by frame time + 100 cycles; the second frame starts 100 cycles after the first pulse.
- **Timeout:** use a behavioural master stub that never raises `i2c_data_out_available` on byte 3; `TIMEOUT_CYCLES`=50 → `timeout_err`=1 fifty cycles into WAIT_DATA, no `sample_valid`, `accel_*` hold previous values. The next good frame clears `timeout_err`.
- **Enable drop mid-frame:** deassert `enable` during byte 2 → the frame completes with one `sample_valid`, the FSM returns to IDLE after GAP, and `i2c_start` stays 0 thereafter.
- **Async reset mid-transaction:** pulse `reset`=0 for 3 ns while `i2c_start`=1 → `i2c_start`, `busy`, `accel_*` and `timeout_err` go to 0 without waiting for a clock edge. After release with `enable`=1, a fresh frame starts at 0x3B.
- **Held available level:** the stub holds `i2c_data_out_available` high across byte boundaries → each byte is captured once and the slot ordering is correct.
